// File: rtl/bus_read_arbiter_pkg.sv
// Shared definitions for the 3-master AXI read-bus grant generator.
// State and master-index codes, plus the pointer-advance helper.
package bus_read_arbiter_pkg;

    localparam int NUM_MASTERS = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0] M0 = 2'd0;
    localparam logic [1:0] M1 = 2'd1;
    localparam logic [1:0] M2 = 2'd2;

    // Index of the master after the one-hot granted master, wrapping mod 3.
    function automatic logic [1:0] next_ptr(input logic [NUM_MASTERS-1:0] onehot);
        logic [1:0] nxt;
        case (onehot)
            3'b001:  nxt = M1;
            3'b010:  nxt = M2;
            3'b100:  nxt = M0;
            default: nxt = M0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bus_read_arbiter_rr_priority_pick.sv
// Combinational winner pick: rotating priority from a pointer, or fixed
// lowest-index-wins when round-robin is disabled.
module rr_priority_pick
    import bus_read_arbiter_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [1:0]             i_ptr,
    input  logic                   i_rr_en,
    output logic [NUM_MASTERS-1:0] o_win,
    output logic                   o_valid
);

    logic [1:0] w_start;
    logic [2:0] w_sum;
    logic [1:0] w_idx;
    logic       w_found;

    always_comb begin
        o_win   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        // A pointer of 3 cannot be reached; fold it onto m0 defensively.
        w_start = (i_rr_en && (i_ptr != 2'd3)) ? i_ptr : M0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_sum = {1'b0, w_start} + 3'(k);
            if (w_sum >= 3'd3) w_sum = w_sum - 3'd3;
            w_idx = w_sum[1:0];
            if (!w_found && i_req[w_idx]) begin
                o_win[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/bus_read_arbiter.sv
// Read-bus grant generator: holds one master's grant from AR issue until the
// final R beat handshakes, with one idle turnaround cycle between grants.
module bus_read_arbiter
    import bus_read_arbiter_pkg::*;
#(
    parameter logic RR_EN = 1'b1
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic m0_arvalid,
    input  logic m1_arvalid,
    input  logic m2_arvalid,
    input  logic arvalid,
    input  logic arready,
    input  logic rvalid,
    input  logic rready,
    input  logic rlast,
    output logic m0_grnt,
    output logic m1_grnt,
    output logic m2_grnt,
    output logic bus_busy
);

    logic [1:0]             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [1:0]             r_ptr;

    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_pick;
    logic                   w_pick_vld;
    logic                   w_ar_hs;
    logic                   w_r_done;

    assign w_req    = {m2_arvalid, m1_arvalid, m0_arvalid};
    assign w_ar_hs  = arvalid & arready;
    assign w_r_done = rvalid & rready & rlast;

    rr_priority_pick u_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .i_rr_en (RR_EN),
        .o_win   (w_pick),
        .o_valid (w_pick_vld)
    );

    // Bus handshakes only matter in ADDR/DATA; requests only in IDLE.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= M0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_grant <= w_pick;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_ar_hs) r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_r_done) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_ptr   <= next_ptr(r_grant);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign m0_grnt  = r_grant[0];
    assign m1_grnt  = r_grant[1];
    assign m2_grnt  = r_grant[2];
    assign bus_busy = |r_grant;

endmodule

// File: tb/tb_bus_read_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one
// stimulus stream; outputs are checked one time unit after each rising edge.
module tb_bus_read_arbiter;

    logic aclk = 1'b0;
    logic aresetn;
    logic m0_arvalid, m1_arvalid, m2_arvalid;
    logic arvalid, arready, rvalid, rready, rlast;
    logic rr_m0, rr_m1, rr_m2, rr_busy;
    logic fp_m0, fp_m1, fp_m2, fp_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    bus_read_arbiter #(.RR_EN(1'b1)) dut_rr (
        .aclk(aclk), .aresetn(aresetn),
        .m0_arvalid(m0_arvalid), .m1_arvalid(m1_arvalid), .m2_arvalid(m2_arvalid),
        .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .m0_grnt(rr_m0), .m1_grnt(rr_m1), .m2_grnt(rr_m2), .bus_busy(rr_busy)
    );

    bus_read_arbiter #(.RR_EN(1'b0)) dut_fp (
        .aclk(aclk), .aresetn(aresetn),
        .m0_arvalid(m0_arvalid), .m1_arvalid(m1_arvalid), .m2_arvalid(m2_arvalid),
        .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .m0_grnt(fp_m0), .m1_grnt(fp_m1), .m2_grnt(fp_m2), .bus_busy(fp_busy)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] r);
        {m2_arvalid, m1_arvalid, m0_arvalid} = r;
    endtask

    task automatic set_bus(input logic av, input logic ar, input logic rv,
                           input logic rr, input logic rl);
        arvalid = av; arready = ar; rvalid = rv; rready = rr; rlast = rl;
    endtask

    // Expected values are {bus_busy, m2, m1, m0}.
    task automatic check(input string tag, input logic [3:0] exp_rr, input logic [3:0] exp_fp);
        logic [3:0] obs_rr, obs_fp;
        obs_rr = {rr_busy, rr_m2, rr_m1, rr_m0};
        obs_fp = {fp_busy, fp_m2, fp_m1, fp_m0};
        n_checks++;
        assert (obs_rr === exp_rr) else begin
            n_fail++;
            $error("FAIL %s rr: observed=%b expected=%b", tag, obs_rr, exp_rr);
        end
        n_checks++;
        assert (obs_fp === exp_fp) else begin
            n_fail++;
            $error("FAIL %s fp: observed=%b expected=%b", tag, obs_fp, exp_fp);
        end
    endtask

    localparam logic [3:0] G_NONE = 4'b0000;
    localparam logic [3:0] G_M0   = 4'b1001;
    localparam logic [3:0] G_M1   = 4'b1010;
    localparam logic [3:0] G_M2   = 4'b1100;

    logic [3:0] rr_order [4];

    initial begin
        rr_order[0] = G_M0; rr_order[1] = G_M1; rr_order[2] = G_M2; rr_order[3] = G_M0;

        // Reset held two cycles with every master requesting.
        aresetn = 1'b0;
        set_req(3'b111);
        set_bus(0, 0, 0, 0, 0);
        #1;
        tick();
        tick();
        check("reset", G_NONE, G_NONE);
        aresetn = 1'b1;
        tick();
        check("first_after_reset", G_M0, G_M0);
        set_req(3'b000);
        set_bus(1, 1, 0, 0, 0);
        tick();
        set_bus(0, 0, 1, 1, 1);
        tick();
        check("first_done", G_NONE, G_NONE);
        set_bus(0, 0, 0, 0, 0);

        // Single m1 transaction: AR at t+3, 16 beats ending at t+20.
        set_req(3'b010);
        tick();
        for (int c = 1; c <= 20; c++) begin
            check($sformatf("single_hold_%0d", c), G_M1, G_M1);
            set_req(3'b000);
            set_bus(c == 3, c == 3, c >= 5, c >= 5, c == 20);
            tick();
        end
        check("single_release", G_NONE, G_NONE);
        set_bus(0, 0, 0, 0, 0);

        // Fresh reset so the rotation starts from m0, then continuous requests.
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        set_req(3'b111);
        for (int n = 0; n < 4; n++) begin
            tick();
            check($sformatf("order_%0d", n), rr_order[n], G_M0);
            set_bus(1, 1, 0, 0, 0);
            tick();
            set_bus(0, 0, 1, 1, 1);
            tick();
            check($sformatf("turnaround_%0d", n), G_NONE, G_NONE);
            set_bus(0, 0, 0, 0, 0);
        end
        set_req(3'b000);

        // Non-last beats with rready toggling, then a stalled last beat.
        set_req(3'b010);
        tick();
        check("nl_grant", G_M1, G_M1);
        set_req(3'b000);
        set_bus(1, 1, 0, 0, 0);
        tick();
        for (int b = 0; b < 4; b++) begin
            set_bus(0, 0, 1, (b % 2) == 0, 0);
            tick();
            check($sformatf("nl_beat_%0d", b), G_M1, G_M1);
        end
        set_bus(0, 0, 1, 0, 1);
        tick();
        check("last_stalled", G_M1, G_M1);
        set_bus(0, 0, 1, 1, 1);
        tick();
        check("last_accepted", G_NONE, G_NONE);
        set_bus(1, 1, 1, 1, 1);
        tick();
        check("idle_ignores_bus", G_NONE, G_NONE);
        set_bus(0, 0, 0, 0, 0);

        // Reset after the 5th beat of a burst; pointer (2 for rr) must fall to 0.
        set_req(3'b010);
        tick();
        check("mid_grant", G_M1, G_M1);
        set_req(3'b000);
        set_bus(1, 1, 0, 0, 0);
        tick();
        for (int b = 0; b < 5; b++) begin
            set_bus(0, 0, 1, 1, 0);
            tick();
        end
        check("mid_before_reset", G_M1, G_M1);
        set_bus(0, 0, 0, 0, 0);
        aresetn = 1'b0;
        tick();
        check("mid_reset", G_NONE, G_NONE);
        aresetn = 1'b1;
        set_req(3'b101);
        tick();
        check("post_reset_pick", G_M0, G_M0);
        set_req(3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
